// File: rtl/sopc_mem_copy_master_if.sv
// Avalon-MM master bus bundle for sopc_mem_copy_master: word addressing,
// fixed read latency of 1, waitrequest stalls the request.
interface sopc_mem_copy_master_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_chipselect;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_read, avm_write,
           avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_read, avm_write,
           avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/sopc_mem_copy_master.sv
// Word-by-word memory copy engine on an Avalon-MM master port (read, then write).
// Define MEMCOPY_VERIFY_EN to read back every written word and flag mismatches in error.
module sopc_mem_copy_master #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [ADDR_W:0]       length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  sopc_mem_copy_master_if.master avm
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
`ifdef MEMCOPY_VERIFY_EN
    VF_REQ  = 3'd4,
    VF_DATA = 3'd5,
`endif
    FINISH  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                cs_q, cs_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef MEMCOPY_VERIFY_EN
  logic                err_q, err_d;
`endif

  // Next-state and next-output logic; bus outputs are computed for the state being entered.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    read_d  = 1'b0;
    write_d = 1'b0;
`ifdef MEMCOPY_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          cnt_d = length;
`ifdef MEMCOPY_VERIFY_EN
          err_d = 1'b0;
`endif
          if (length == CNT_ZERO) begin
            state_d = FINISH;
          end else begin
            state_d = RD_REQ;
            read_d  = 1'b1;
            addr_d  = src_addr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (avm.avm_waitrequest) begin
          read_d = 1'b1;
        end else begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        data_d  = avm.avm_readdata;
        state_d = WR_REQ;
        write_d = 1'b1;
        addr_d  = dst_q;
      end
      WR_REQ: begin
        if (avm.avm_waitrequest) begin
          write_d = 1'b1;
        end else begin
          src_d = src_q + ADDR_ONE;
          dst_d = dst_q + ADDR_ONE;
          cnt_d = cnt_q - CNT_ONE;
`ifdef MEMCOPY_VERIFY_EN
          state_d = VF_REQ;
          read_d  = 1'b1;
          addr_d  = dst_q;
`else
          if (cnt_q == CNT_ONE) begin
            state_d = FINISH;
          end else begin
            state_d = RD_REQ;
            read_d  = 1'b1;
            addr_d  = src_q + ADDR_ONE;
          end
`endif
        end
      end
`ifdef MEMCOPY_VERIFY_EN
      VF_REQ: begin
        if (avm.avm_waitrequest) begin
          read_d = 1'b1;
        end else begin
          state_d = VF_DATA;
        end
      end
      VF_DATA: begin
        if (avm.avm_readdata != data_q) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        // Count was already decremented when the write was accepted.
        if (cnt_q == CNT_ZERO) begin
          state_d = FINISH;
        end else begin
          state_d = RD_REQ;
          read_d  = 1'b1;
          addr_d  = src_q;
        end
      end
`endif
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cs_d   = read_d | write_d;
    busy_d = (state_d != IDLE) && (state_d != FINISH);
    done_d = (state_d == FINISH);
  end

  // State and registered outputs; reset wins over any request or start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= {ADDR_W{1'b0}};
      dst_q   <= {ADDR_W{1'b0}};
      cnt_q   <= CNT_ZERO;
      data_q  <= {DATA_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      read_q  <= 1'b0;
      write_q <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEMCOPY_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MEMCOPY_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  assign avm.avm_address    = addr_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_read       = read_q;
  assign avm.avm_write      = write_q;
  assign avm.avm_byteenable = {BE_W{cs_q}};
  assign avm.avm_writedata  = data_q;
  assign busy               = busy_q;
  assign done               = done_q;
`ifdef MEMCOPY_VERIFY_EN
  assign error              = err_q;
`else
  assign error              = 1'b0;
`endif

endmodule
